// File: rtl/bcd_digit_sequencer_if.sv
// Handshake and display bus of the BCD digit sequencer.
//   start/value     : conversion request and its binary operand (master -> slave)
//   busy/done       : conversion in progress / one-cycle completion pulse
//   overflow        : last accepted value exceeded 9999
//   bin3..bin0      : thousands..ones nibbles (0..9, or 4'hE on overflow)
//   print           : per-digit display enable, print[k] pairs with bin<k>
interface bcd_digit_sequencer_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       bin3;
    logic [3:0]       bin2;
    logic [3:0]       bin1;
    logic [3:0]       bin0;
    logic [3:0]       print;

    modport master (
        output start, value,
        input  busy, done, overflow, bin3, bin2, bin1, bin0, print
    );

    modport slave (
        input  start, value,
        output busy, done, overflow, bin3, bin2, bin1, bin0, print
    );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Iterative double-dabble binary-to-BCD converter driving a 4-digit
// 7-segment bank (bin3..bin0 + print enables into hex display decoders).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bcd_digit_sequencer_if (start/value in;
//            busy/done/overflow/bin3..bin0/print out, all registered)
// One conversion takes WIDTH SHIFT cycles after the accepting edge; digits
// and print enables hold between completions.
module bcd_digit_sequencer #(
    parameter int WIDTH    = 14,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_digit_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh;
    logic [15:0]      scr;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;

    logic             accept;
    logic             last;

    logic [15:0]      scr_adj;
    logic [15:0]      scr_nxt;
    logic [WIDTH-1:0] sh_nxt;

    logic [15:0]      dig_nxt;
    logic [3:0]       print_nxt;
    logic             ovf_nxt;

    logic [15:0]      dig_q;
    logic [3:0]       print_q;
    logic             ovf_q;
    logic             done_q;

    assign accept = (state == IDLE) && bus.start;
    // The counter is loaded with WIDTH; the edge that takes it to 0 completes.
    assign last   = (state == SHIFT) && (cnt == CW'(1));

    // One double-dabble step: add-3 on every nibble >= 5, then shift
    // {scratch, shift register} left by one. Carry out of scr[15] is dropped;
    // it only happens for out-of-range operands, which display as overflow.
    always_comb begin
        scr_adj = '0;
        for (int i = 0; i < 4; i++) begin
            scr_adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3
                                                         : scr[4*i +: 4];
        end
        scr_nxt = {scr_adj[14:0], sh[WIDTH-1]};
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start during SHIFT is simply ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic: result values registered at the completing edge,
    // built from the post-shift scratch of the final iteration.
    always_comb begin
        dig_nxt   = scr_nxt;
        print_nxt = 4'b1111;
        ovf_nxt   = 1'b0;
        if (ovf_pend) begin
            dig_nxt = 16'hEEEE;
            ovf_nxt = 1'b1;
        end else if (BLANK_LZ) begin
            print_nxt = {|scr_nxt[15:12], |scr_nxt[15:8], |scr_nxt[15:4], 1'b1};
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            dig_q    <= '0;
            print_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                sh       <= bus.value;
                scr      <= '0;
                cnt      <= CW'(WIDTH);
                ovf_pend <= (32'(bus.value) > 32'd9999);
            end else if (state == SHIFT) begin
                sh  <= sh_nxt;
                scr <= scr_nxt;
                cnt <= cnt - CW'(1);
            end
            if (last) begin
                dig_q   <= dig_nxt;
                print_q <= print_nxt;
                ovf_q   <= ovf_nxt;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bin3     = dig_q[15:12];
    assign bus.bin2     = dig_q[11:8];
    assign bus.bin1     = dig_q[7:4];
    assign bus.bin0     = dig_q[3:0];
    assign bus.print    = print_q;
endmodule
